entrada_jogada: RTL and testbench
=================================

// Module: entrada_jogada
// PURPOSE
//  Conditions the 9 board push-buttons into one validated move for the game control unit.
//  - Synchronises the buttons and debounces the press.
//  - Rejects multi-button presses.
//  - Encodes the pressed button to a 4-bit cell index and holds it, with tem_jogada high, until the control unit registers it.
//  - Then waits for full release before a new move is accepted.
//  Sits directly upstream of unidade_controle (feeds tem_jogada) and of the macro/micro position registers (feeds jogada).
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  stable cycles needed to accept a press or a release (1 ms @ 50 MHz); >=2
//  CW               16     debounce counter width; must satisfy 2**CW > DEBOUNCE_CYCLES
// PORTS
//  clock        in   1  system clock; single clock domain, all flops on posedge
//  reset        in   1  synchronous, active-high; overrides every other input
//  zera         in   1  sync clear to ESPERA, same effect as reset (driven by zeraEdge)
//  habilita     in   1  press acceptance enable (jogar_macro | jogar_micro)
//  consome      in   1  move taken (registraR_macro | registraR_micro)
//  botoes       in   9  raw asynchronous buttons, bit i = board cell i, active-high
//  tem_jogada   out  1  valid move held; registered
//  jogada       out  4  cell index 0..8 of held move; 4'hF when none
//  db_estado    out  3  current FSM state, for 7-seg debug
// BEHAVIOUR
//  - Reset or zera:
//    - FSM <= ESPERA, counter <= 0, tem_jogada <= 0, jogada <= 4'hF.
//    - Synchroniser flops <= 0.
//    - Reset wins over all inputs; mid-debounce or mid-hold state is discarded.
//  - Input conditioning:
//    - botoes pass through 2 flops (b_s); b_s is used everywhere below.
//    - Latency from a raw edge to b_s is 2 cycles.
//    - unico = b_s is one-hot (exactly one bit set).
//  - FSM (Moore); db_estado = encoding:
//    - ESPERA (0):
//      - habilita & unico -> FILTRA; capture cand <= b_s; cnt <= 0.
//      - Otherwise stay. Multi-press or no press: stay.
//    - FILTRA (1):
//      - b_s != cand or !habilita -> ESPERA.
//      - Else if cnt == DEBOUNCE_CYCLES-1 -> PRONTO; jogada <= index(cand); tem_jogada <= 1.
//      - Else cnt++.
//    - PRONTO (2):
//      - tem_jogada = 1 and jogada is held constant regardless of botoes/habilita.
//      - consome -> SOLTA; tem_jogada <= 0; jogada <= 4'hF; cnt <= 0.
//    - SOLTA (3):
//      - b_s != 0 -> cnt <= 0, stay.
//      - Else if cnt == DEBOUNCE_CYCLES-1 -> ESPERA.
//      - Else cnt++.
//      - Presses here are ignored, even with habilita high.
//    - Unused encodings -> ESPERA; db_estado = 3'b111 is reserved as error.
//  - Press acceptance timing: tem_jogada rises exactly DEBOUNCE_CYCLES+1 cycles after the first cycle with b_s one-hot in ESPERA.
//  - consome asserted outside PRONTO: ignored.
//  - consome and a button change in the same PRONTO cycle: consome wins; SOLTA then waits for release.
//  - habilita low while in PRONTO: the move stays held; it is not cancelled.
//  - Counter saturates; it never wraps (cnt only advances while < DEBOUNCE_CYCLES-1).
//  - index(cand) is the position of the set bit, zero-extended to 4 bits (bit 8 -> 4'h8).
// STRUCTURE
//  - Package jogo_pkg:
//    - State localparams ESPERA/FILTRA/PRONTO/SOLTA (3-bit).
//    - JOGADA_NULA = 4'hF.
//    - N_CELULAS = 9.
//    - Function onehot_para_indice(9b) -> 4b.
//  - Sub-module sincronizador_botoes: 9-bit, 2-flop synchroniser with sync reset.
//  - Top level holds the FSM, counter, cand and the output registers.
// TESTING (bench with DEBOUNCE_CYCLES=4)
//  1. Hold botoes=9'b000010000 with habilita=1 -> tem_jogada=1 on cycle 7 after the edge; jogada=4'h4; held until consome.
//     Then consome pulse -> tem_jogada=0, jogada=4'hF on the next cycle.
//  2. Bounce: toggle bit 0 every 2 cycles for 10 cycles, then hold -> exactly one tem_jogada assertion, jogada=4'h0.
//  3. botoes=9'b100000001 (two pressed) -> tem_jogada stays 0 and FSM stays in ESPERA.
//     Release bit 0 -> jogada=4'h8 accepted after debounce.
//  4. After consome, keep bit 8 held 20 cycles, release for 2 cycles, press again -> no new move.
//     Release for 4+ cycles, then press bit 3 -> jogada=4'h3.
//  5. habilita=0 while pressing -> no move.
//     habilita drops in FILTRA -> back to ESPERA.
//     habilita drops in PRONTO -> move still held.
//  6. Assert reset (and separately zera) during FILTRA and during PRONTO -> next cycle tem_jogada=0, jogada=4'hF, db_estado=0.

Source files
------------

// File: rtl/jogo_pkg.sv
// jogo_pkg: shared states, constants and cell-index helper for the board input path
package jogo_pkg;
    typedef enum logic [2:0] {
        ESPERA = 3'd0,
        FILTRA = 3'd1,
        PRONTO = 3'd2,
        SOLTA  = 3'd3
    } estado_t;
    localparam logic [3:0] JOGADA_NULA = 4'hF;
    localparam int N_CELULAS = 9;
    function automatic logic [3:0] onehot_para_indice(input logic [N_CELULAS-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < N_CELULAS; i++)
            if (v[i]) r = 4'(i);
        return r;
    endfunction
endpackage

// File: rtl/sincronizador_botoes.sv
// sincronizador_botoes: two-flop synchroniser for the asynchronous board buttons
module sincronizador_botoes
    import jogo_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_CELULAS-1:0] d,
    output logic [N_CELULAS-1:0] q
);
    logic [N_CELULAS-1:0] m;
    always_ff @(posedge clock)
        if (reset) {q, m} <= '0;
        else       {q, m} <= {m, d};
endmodule

// File: rtl/entrada_jogada.sv
// entrada_jogada: debounces the board buttons into one validated, held move
module entrada_jogada
    import jogo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CW              = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 zera,
    input  logic                 habilita,
    input  logic                 consome,
    input  logic [N_CELULAS-1:0] botoes,
    output logic                 tem_jogada,
    output logic [3:0]           jogada,
    output logic [2:0]           db_estado
);
    logic [N_CELULAS-1:0] b_s, cand;
    logic [CW-1:0] cnt;
    estado_t estado;
    logic limpa, unico, limite;
    assign limpa     = reset | zera;
    assign unico     = $onehot(b_s);
    assign limite    = cnt == CW'(DEBOUNCE_CYCLES - 1);
    assign db_estado = estado;
    sincronizador_botoes u_sinc (
        .clock(clock),
        .reset(limpa),
        .d    (botoes),
        .q    (b_s)
    );
    always_ff @(posedge clock)
        if (limpa) begin
            estado     <= ESPERA;
            cnt        <= '0;
            cand       <= '0;
            tem_jogada <= 1'b0;
            jogada     <= JOGADA_NULA;
        end else
            case (estado)
                ESPERA:
                    if (habilita && unico) begin
                        estado <= FILTRA;
                        cand   <= b_s;
                        cnt    <= '0;
                    end
                FILTRA:
                    if (b_s != cand || !habilita) estado <= ESPERA;
                    else if (limite) begin
                        estado     <= PRONTO;
                        jogada     <= onehot_para_indice(cand);
                        tem_jogada <= 1'b1;
                    end else cnt <= cnt + CW'(1);
                PRONTO:
                    if (consome) begin
                        estado     <= SOLTA;
                        tem_jogada <= 1'b0;
                        jogada     <= JOGADA_NULA;
                        cnt        <= '0;
                    end
                SOLTA:
                    if (b_s != '0) cnt <= '0;
                    else if (limite) estado <= ESPERA;
                    else cnt <= cnt + CW'(1);
                default: begin
                    estado     <= ESPERA;
                    tem_jogada <= 1'b0;
                    jogada     <= JOGADA_NULA;
                end
            endcase
endmodule

// File: tb/tb_entrada_jogada.sv
// tb_entrada_jogada: directed scoreboard bench for entrada_jogada with a short debounce
module tb_entrada_jogada;
    logic clock = 1'b0;
    logic reset, zera, habilita, consome;
    logic [8:0] botoes;
    logic tem_jogada;
    logic [3:0] jogada;
    logic [2:0] db_estado;
    int total = 0;
    int bad = 0;
    logic [3:0] fila[$];
    logic tem_ant = 1'b0;

    entrada_jogada #(.DEBOUNCE_CYCLES(4), .CW(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .zera      (zera),
        .habilita  (habilita),
        .consome   (consome),
        .botoes    (botoes),
        .tem_jogada(tem_jogada),
        .jogada    (jogada),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic saida(input string tag, input logic t, input logic [3:0] j, input logic [2:0] e);
        chk({tag, "_tem"}, 8'(tem_jogada), 8'(t));
        chk({tag, "_jog"}, 8'(jogada), 8'(j));
        chk({tag, "_est"}, 8'(db_estado), 8'(e));
    endtask

    // every rising edge of tem_jogada must match the next expected move
    always @(negedge clock) begin
        if (tem_jogada && !tem_ant) begin
            total++;
            assert (fila.size() > 0) else begin
                bad++;
                $error("FAIL scoreboard_extra got=%0h exp=none", jogada);
            end
            if (fila.size() > 0) chk("scoreboard_jogada", 8'(jogada), 8'(fila.pop_front()));
        end
        tem_ant <= tem_jogada;
    end

    task automatic consumir_e_soltar;
        consome = 1'b1;
        tick();
        consome = 1'b0;
        botoes = '0;
        tick(8);
    endtask

    initial begin
        reset = 1'b1; zera = 1'b0; habilita = 1'b0; consome = 1'b0; botoes = '0;
        tick(3);
        saida("reset", 1'b0, 4'hF, 3'd0);
        reset = 1'b0;
        tick();

        // 1: clean press of cell 4, exact latency, hold, consume
        habilita = 1'b1;
        botoes = 9'b000010000;
        fila.push_back(4'h4);
        tick(6);
        saida("t1_antes", 1'b0, 4'hF, 3'd1);
        tick();
        saida("t1_aceita", 1'b1, 4'h4, 3'd2);
        tick(5);
        saida("t1_segura", 1'b1, 4'h4, 3'd2);
        consome = 1'b1;
        tick();
        consome = 1'b0;
        saida("t1_consome", 1'b0, 4'hF, 3'd3);
        botoes = '0;
        tick(8);
        chk("t1_volta", 8'(db_estado), 8'd0);

        // 2: bouncing cell 0 yields exactly one move
        for (int i = 0; i < 10; i++) begin
            botoes = ((i / 2) % 2 == 0) ? 9'b000000001 : 9'b000000000;
            tick();
        end
        botoes = 9'b000000001;
        fila.push_back(4'h0);
        tick(12);
        saida("t2_bounce", 1'b1, 4'h0, 3'd2);
        consumir_e_soltar();

        // 3: two buttons rejected, then releasing one accepts cell 8
        botoes = 9'b100000001;
        tick(10);
        saida("t3_duplo", 1'b0, 4'hF, 3'd0);
        botoes = 9'b100000000;
        fila.push_back(4'h8);
        tick(10);
        saida("t3_unico", 1'b1, 4'h8, 3'd2);
        consome = 1'b1;
        tick();
        consome = 1'b0;

        // 4: presses during release wait are ignored
        tick(20);
        saida("t4_segura", 1'b0, 4'hF, 3'd3);
        botoes = '0;
        tick(2);
        botoes = 9'b100000000;
        tick(10);
        saida("t4_repress", 1'b0, 4'hF, 3'd3);
        botoes = '0;
        tick(8);
        chk("t4_solto", 8'(db_estado), 8'd0);
        botoes = 9'b000001000;
        fila.push_back(4'h3);
        tick(10);
        saida("t4_nova", 1'b1, 4'h3, 3'd2);
        consumir_e_soltar();

        // 5: habilita gating
        habilita = 1'b0;
        botoes = 9'b000100000;
        tick(10);
        saida("t5_desab", 1'b0, 4'hF, 3'd0);
        botoes = '0;
        tick(3);
        habilita = 1'b1;
        botoes = 9'b000000100;
        tick(4);
        chk("t5_filtra", 8'(db_estado), 8'd1);
        habilita = 1'b0;
        tick();
        saida("t5_cancela", 1'b0, 4'hF, 3'd0);
        botoes = '0;
        tick(3);
        habilita = 1'b1;
        botoes = 9'b001000000;
        fila.push_back(4'h6);
        tick(9);
        chk("t5_pronto", 8'(tem_jogada), 8'd1);
        habilita = 1'b0;
        botoes = '0;
        tick(5);
        saida("t5_mantem", 1'b1, 4'h6, 3'd2);
        habilita = 1'b1;
        consumir_e_soltar();

        // 6: reset and zera discard FILTRA and PRONTO
        for (int k = 0; k < 2; k++) begin
            botoes = 9'b000000010;
            tick(4);
            chk("t6_filtra", 8'(db_estado), 8'd1);
            if (k == 0) reset = 1'b1; else zera = 1'b1;
            botoes = '0;
            tick();
            saida(k == 0 ? "t6_reset_f" : "t6_zera_f", 1'b0, 4'hF, 3'd0);
            reset = 1'b0; zera = 1'b0;
            tick(3);
            botoes = 9'b010000000;
            fila.push_back(4'h7);
            tick(9);
            chk("t6_pronto", 8'(tem_jogada), 8'd1);
            if (k == 0) reset = 1'b1; else zera = 1'b1;
            botoes = '0;
            tick();
            saida(k == 0 ? "t6_reset_p" : "t6_zera_p", 1'b0, 4'hF, 3'd0);
            reset = 1'b0; zera = 1'b0;
            tick(3);
        end

        chk("fila_vazia", 8'(fila.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
